// File: rtl/mips_test_sequencer.sv
// Bring-up test sequencer for the pipelined MIPS core: resets the core for each
// program, optionally fires one interrupt, waits for completion and scores the result.
module mips_test_sequencer #(
    parameter int DATA_W     = 32,
    parameter int NUM_TESTS  = 10,
    parameter int IDX_W      = 4,
    parameter int RST_CYCLES = 3,
    parameter int CYC_W      = 16,
    parameter int TIMEOUT    = 4000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_done,
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_expected,
    input  logic              i_irq_en,
    input  logic [CYC_W-1:0]  i_irq_cycle,
    output logic              o_core_rst_n,
    output logic              o_ext_irq,
    output logic [IDX_W-1:0]  o_test_idx,
    output logic              o_busy,
    output logic              o_run_done,
    output logic              o_all_pass,
    output logic [IDX_W:0]    o_error_count,
    output logic [IDX_W:0]    o_timeout_count,
    output logic              o_fail_valid,
    output logic [IDX_W-1:0]  o_fail_idx
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 1);
    localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W + 1)'(NUM_TESTS);

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        CHECK,
        NEXT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CYC_W-1:0]  cycle_cnt;
    logic [RST_W-1:0]  rst_cnt;
    logic              done_q;
    logic              done_edge;
    logic              timed_out;
    logic              mismatch;
    logic              last_test;

    function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] value);
        return (value == CNT_MAX) ? value : value + (IDX_W + 1)'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An edge arriving on the final RUN cycle wins over the timeout.
    always_comb begin
        done_edge  = i_done & ~done_q;
        timed_out  = (cycle_cnt == CYC_LAST) & ~done_edge;
        mismatch   = (i_result != i_expected);
        last_test  = (o_test_idx == IDX_LAST);
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RESET;
            RESET:   if (rst_cnt == RST_LAST) state_next = RUN;
            RUN: begin
                if (done_edge) begin
                    state_next = CHECK;
                end else if (timed_out) begin
                    state_next = NEXT;
                end
            end
            CHECK:   state_next = NEXT;
            NEXT:    state_next = last_test ? IDLE : RESET;
            default: state_next = IDLE;
        endcase
    end

    assign o_core_rst_n = (state == RUN) || (state == CHECK) || (state == NEXT);
    assign o_busy       = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_cnt       <= '0;
            rst_cnt         <= '0;
            done_q          <= 1'b0;
            o_ext_irq       <= 1'b0;
            o_test_idx      <= '0;
            o_run_done      <= 1'b0;
            o_all_pass      <= 1'b0;
            o_error_count   <= '0;
            o_timeout_count <= '0;
            o_fail_valid    <= 1'b0;
            o_fail_idx      <= '0;
        end else begin
            done_q       <= i_done;
            o_ext_irq    <= 1'b0;
            o_run_done   <= 1'b0;
            o_fail_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_error_count   <= '0;
                        o_timeout_count <= '0;
                        o_test_idx      <= '0;
                        o_all_pass      <= 1'b0;
                        rst_cnt         <= '0;
                    end
                end
                RESET: begin
                    cycle_cnt <= '0;
                    rst_cnt   <= rst_cnt + RST_W'(1);
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + CYC_W'(1);
                    o_ext_irq <= i_irq_en && (cycle_cnt == i_irq_cycle);
                    if (timed_out) begin
                        o_fail_valid    <= 1'b1;
                        o_fail_idx      <= o_test_idx;
                        o_error_count   <= sat_inc(o_error_count);
                        o_timeout_count <= sat_inc(o_timeout_count);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        o_fail_valid  <= 1'b1;
                        o_fail_idx    <= o_test_idx;
                        o_error_count <= sat_inc(o_error_count);
                    end
                end
                NEXT: begin
                    rst_cnt <= '0;
                    if (last_test) begin
                        o_run_done <= 1'b1;
                        o_all_pass <= (o_error_count == '0);
                    end else begin
                        o_test_idx <= o_test_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Scoreboard bench for mips_test_sequencer: a per-test timing model predicts every
// reset release, interrupt, failure report and end-of-run summary.
module tb_mips_test_sequencer;

    localparam int DATA_W     = 32;
    localparam int NUM_TESTS  = 3;
    localparam int IDX_W      = 2;
    localparam int RST_CYCLES = 3;
    localparam int CYC_W      = 16;
    localparam int TIMEOUT    = 50;
    localparam int TBL        = 1 << IDX_W;
    localparam int RUN_BUDGET = NUM_TESTS * (RST_CYCLES + TIMEOUT + 2) + 20;

    typedef struct {
        int at;
        int idx;
        int err;
        int tmo;
        bit pass;
    } ev_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] expected;
    logic              irq_en;
    logic [CYC_W-1:0]  irq_cycle;
    logic              core_rst_n;
    logic              ext_irq;
    logic [IDX_W-1:0]  test_idx;
    logic              busy;
    logic              run_done;
    logic              all_pass;
    logic [IDX_W:0]    error_count;
    logic [IDX_W:0]    timeout_count;
    logic              fail_valid;
    logic [IDX_W-1:0]  fail_idx;

    int                done_tab[TBL];
    logic [DATA_W-1:0] res_tab[TBL];
    logic [DATA_W-1:0] exp_tab[TBL];
    bit                irq_en_tab[TBL];
    int                irq_cyc_tab[TBL];
    bit                stale_tab[TBL];
    int                drop_tab[TBL];

    ev_t rise_sb[$];
    ev_t irq_sb[$];
    ev_t fail_sb[$];
    ev_t end_sb[$];

    int   cyc;
    int   n_checks;
    int   n_fails;
    int   core_k;
    bit   last_pass;
    logic prev_rst_n;

    mips_test_sequencer #(
        .DATA_W     (DATA_W),
        .NUM_TESTS  (NUM_TESTS),
        .IDX_W      (IDX_W),
        .RST_CYCLES (RST_CYCLES),
        .CYC_W      (CYC_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_done          (done),
        .i_result        (result),
        .i_expected      (expected),
        .i_irq_en        (irq_en),
        .i_irq_cycle     (irq_cycle),
        .o_core_rst_n    (core_rst_n),
        .o_ext_irq       (ext_irq),
        .o_test_idx      (test_idx),
        .o_busy          (busy),
        .o_run_done      (run_done),
        .o_all_pass      (all_pass),
        .o_error_count   (error_count),
        .o_timeout_count (timeout_count),
        .o_fail_valid    (fail_valid),
        .o_fail_idx      (fail_idx)
    );

    assign result    = res_tab[test_idx];
    assign expected  = exp_tab[test_idx];
    assign irq_en    = irq_en_tab[test_idx];
    assign irq_cycle = CYC_W'(irq_cyc_tab[test_idx]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Core stand-in: done rises done_tab RUN cycles after reset release; a stale
    // test keeps done high through reset until drop_tab cycles into RUN.
    always @(negedge clk) begin
        if (!core_rst_n) begin
            core_k = 0;
            done   = stale_tab[test_idx];
        end else begin
            done = (done_tab[test_idx] >= 0 && core_k >= done_tab[test_idx]) ||
                   (stale_tab[test_idx] && core_k < drop_tab[test_idx]);
            core_k = core_k + 1;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name, input string what);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Monitor: pops the matching scoreboard queue whenever the DUT shows an event.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            if (core_rst_n && !prev_rst_n) begin
                if (rise_sb.size() == 0) begin
                    report_fail("core_rst_rise", "unexpected reset release, required none");
                end else begin
                    ev = rise_sb.pop_front();
                    check_output("core_rst_rise_cycle", cyc, ev.at);
                    check_output("core_rst_rise_idx", test_idx, ev.idx);
                end
            end
            if (ext_irq) begin
                if (irq_sb.size() == 0) begin
                    report_fail("ext_irq", "unexpected interrupt pulse, required none");
                end else begin
                    ev = irq_sb.pop_front();
                    check_output("ext_irq_cycle", cyc, ev.at);
                end
            end
            if (fail_valid) begin
                if (fail_sb.size() == 0) begin
                    report_fail("fail_valid", "unexpected failure report, required none");
                end else begin
                    ev = fail_sb.pop_front();
                    check_output("fail_cycle", cyc, ev.at);
                    check_output("fail_idx", fail_idx, ev.idx);
                end
            end
            if (run_done) begin
                if (end_sb.size() == 0) begin
                    report_fail("run_done", "unexpected run_done pulse, required none");
                end else begin
                    ev = end_sb.pop_front();
                    check_output("run_done_cycle", cyc, ev.at);
                    check_output("error_count", error_count, ev.err);
                    check_output("timeout_count", timeout_count, ev.tmo);
                    check_output("all_pass", all_pass, ev.pass);
                    check_output("done_busy", busy, 0);
                    check_output("done_test_idx", test_idx, ev.idx);
                end
            end
        end
        prev_rst_n = core_rst_n;
    end

    task automatic set_test(input int i, input int d, input logic [31:0] res, input logic [31:0] exp,
                            input bit en, input int ic, input bit st, input int dr);
        done_tab[i]    = d;
        res_tab[i]     = res;
        exp_tab[i]     = exp;
        irq_en_tab[i]  = en;
        irq_cyc_tab[i] = ic;
        stale_tab[i]   = st;
        drop_tab[i]    = dr;
    endtask

    // Reference model: each test lasts RST_CYCLES, then L RUN cycles, then CHECK and
    // NEXT (a timeout skips CHECK). Called at a negedge; start is sampled next posedge.
    task automatic apply_stimulus(input bit restart_mid);
        int  b;
        int  l;
        int  err;
        int  tmo;
        int  n;
        bit  comp;
        bit  bad;
        ev_t ev;
        b   = cyc + 1;
        err = 0;
        tmo = 0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            comp = (done_tab[i] >= 0) && (done_tab[i] < TIMEOUT);
            l    = comp ? done_tab[i] + 1 : TIMEOUT;
            bad  = !comp || (res_tab[i] != exp_tab[i]);
            if (bad) err++;
            if (!comp) tmo++;
            ev = '{at: b + RST_CYCLES, idx: i, err: 0, tmo: 0, pass: 1'b0};
            rise_sb.push_back(ev);
            if (irq_en_tab[i] && irq_cyc_tab[i] < l) begin
                ev.at = b + RST_CYCLES + irq_cyc_tab[i] + 1;
                irq_sb.push_back(ev);
            end
            if (bad) begin
                ev.at = b + RST_CYCLES + l + (comp ? 1 : 0);
                fail_sb.push_back(ev);
            end
            b = b + RST_CYCLES + l + (comp ? 2 : 1);
        end
        last_pass = (err == 0);
        ev = '{at: b, idx: NUM_TESTS - 1, err: err, tmo: tmo, pass: last_pass};
        end_sb.push_back(ev);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (end_sb.size() != 0 && n < RUN_BUDGET) begin
            start = restart_mid && (n == 10);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (end_sb.size() != 0) report_fail("run_end", "run_done not seen within cycle budget");
        check_output("leftover_rise", rise_sb.size(), 0);
        check_output("leftover_irq", irq_sb.size(), 0);
        check_output("leftover_fail", fail_sb.size(), 0);
        rise_sb.delete();
        irq_sb.delete();
        fail_sb.delete();
        end_sb.delete();
        repeat (3) @(negedge clk);
        check_output("idle_all_pass_hold", all_pass, last_pass);
        check_output("idle_busy", busy, 0);
        check_output("idle_core_rst_n", core_rst_n, 0);
    endtask

    task automatic abort_run();
        int n;
        for (int i = 0; i < NUM_TESTS; i++) begin
            set_test(i, 30, 32'h55 + i, (i == 0) ? 32'h0 : 32'h55 + i, 1'b0, 0, 1'b0, 0);
        end
        @(negedge clk);
        last_pass = 1'b0;
        begin
            ev_t ev;
            ev = '{at: cyc + 1 + RST_CYCLES, idx: 0, err: 0, tmo: 0, pass: 1'b0};
            for (int i = 0; i < NUM_TESTS; i++) begin
                ev.idx = i;
                rise_sb.push_back(ev);
                ev.at = ev.at + RST_CYCLES + 33;
            end
            ev = '{at: cyc + 1 + RST_CYCLES + 32, idx: 0, err: 0, tmo: 0, pass: 1'b0};
            fail_sb.push_back(ev);
            ev = '{at: cyc + 1 + NUM_TESTS * (RST_CYCLES + 33), idx: NUM_TESTS - 1, err: 1, tmo: 0, pass: 1'b0};
            end_sb.push_back(ev);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(test_idx == IDX_W'(2) && core_rst_n) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) report_fail("abort_reach_test2", "test 2 RUN never reached");
        repeat (5) @(negedge clk);
        check_output("pre_abort_error_count", error_count, 1);
        rst = 1'b1;
        #1;
        check_output("abort_core_rst_n", core_rst_n, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_test_idx", test_idx, 0);
        check_output("abort_error_count", error_count, 0);
        check_output("abort_timeout_count", timeout_count, 0);
        check_output("abort_run_done", run_done, 0);
        check_output("abort_fail_valid", fail_valid, 0);
        check_output("abort_ext_irq", ext_irq, 0);
        check_output("abort_pending_rise", rise_sb.size(), 0);
        check_output("abort_pending_fail", fail_sb.size(), 0);
        check_output("abort_pending_end", end_sb.size(), 1);
        rise_sb.delete();
        irq_sb.delete();
        fail_sb.delete();
        end_sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (RUN_BUDGET) @(negedge clk);
        check_output("post_abort_core_rst_n", core_rst_n, 0);
    endtask

    initial begin
        int          d;
        int          dr;
        bit          st;
        logic [31:0] e;
        n_checks   = 0;
        n_fails    = 0;
        core_k     = 0;
        prev_rst_n = 1'b0;
        for (int i = 0; i < TBL; i++) set_test(i, 20, 32'h0, 32'h0, 1'b0, 0, 1'b0, 0);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_core_rst_n", core_rst_n, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_test_idx", test_idx, 0);
        check_output("reset_error_count", error_count, 0);
        check_output("reset_timeout_count", timeout_count, 0);
        check_output("reset_run_done", run_done, 0);
        check_output("reset_all_pass", all_pass, 0);
        check_output("reset_fail_valid", fail_valid, 0);
        check_output("reset_fail_idx", fail_idx, 0);
        check_output("reset_ext_irq", ext_irq, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] run: all tests pass");
        for (int i = 0; i < NUM_TESTS; i++) set_test(i, 20, 32'h1000 + i, 32'h1000 + i, 1'b0, 0, 1'b0, 0);
        apply_stimulus(1'b0);

        $display("[TB] run: test 1 mismatch, stray start mid-run");
        for (int i = 0; i < NUM_TESTS; i++) set_test(i, 15, 32'h2000 + i, 32'h2000 + i, 1'b0, 0, 1'b0, 0);
        set_test(1, 15, 32'h8f0ff00b, 32'h0ffffffc, 1'b0, 0, 1'b0, 0);
        apply_stimulus(1'b1);

        $display("[TB] run: timeout and interrupts");
        set_test(0, -1, 32'h3000, 32'h3000, 1'b0, 0, 1'b0, 0);
        set_test(1, 12, 32'h3001, 32'h3001, 1'b1, 5, 1'b0, 0);
        set_test(2, 8, 32'h3002, 32'h3002, 1'b0, 3, 1'b0, 0);
        apply_stimulus(1'b0);

        $display("[TB] run: stale done flag");
        set_test(0, 10, 32'h4000, 32'h4000, 1'b0, 0, 1'b1, 4);
        set_test(1, 5, 32'h4001, 32'h4001, 1'b0, 0, 1'b0, 0);
        set_test(2, -1, 32'h4002, 32'h4002, 1'b0, 0, 1'b1, 2);
        apply_stimulus(1'b0);

        $display("[TB] run: boundaries");
        set_test(0, TIMEOUT - 1, 32'h5000, 32'h5000, 1'b1, TIMEOUT - 1, 1'b0, 0);
        set_test(1, 0, 32'h5001, 32'h5001, 1'b1, 1, 1'b0, 0);
        set_test(2, TIMEOUT, 32'h5002, 32'h5002, 1'b1, 0, 1'b0, 0);
        apply_stimulus(1'b0);

        $display("[TB] runs: randomized");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_TESTS; i++) begin
                st = ($urandom_range(0, 3) == 0);
                dr = int'($urandom_range(1, 4));
                if ($urandom_range(0, 7) == 0) d = -1;
                else if (st) d = dr + int'($urandom_range(1, 50));
                else d = int'($urandom_range(0, 55));
                e = $urandom;
                set_test(i, d, ($urandom_range(0, 3) == 0) ? (e ^ (32'h1 << $urandom_range(0, 31))) : e,
                         e, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 60)), st, dr);
            end
            apply_stimulus(1'b0);
        end

        $display("[TB] run: asynchronous abort in test 2");
        abort_run();

        $display("[TB] run: rerun after abort");
        for (int i = 0; i < NUM_TESTS; i++) set_test(i, 7, 32'h6000 + i, 32'h6000 + i, 1'b1, 2, 1'b0, 0);
        apply_stimulus(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
